// File: rtl/lights_pkg.sv
// lights_pkg: shared index width, palette colour indices and default channel width.
package lights_pkg;
   localparam int IDX_W    = 3;
   localparam int CH_W_DEF = 8;
   typedef logic [IDX_W-1:0] idx_t;
   localparam idx_t COL_BLACK   = 3'd0;
   localparam idx_t COL_BLUE    = 3'd1;
   localparam idx_t COL_GREEN   = 3'd2;
   localparam idx_t COL_CYAN    = 3'd3;
   localparam idx_t COL_RED     = 3'd4;
   localparam idx_t COL_MAGENTA = 3'd5;
   localparam idx_t COL_YELLOW  = 3'd6;
   localparam idx_t COL_WHITE   = 3'd7;
endpackage

// File: rtl/lights_palette.sv
// lights_palette: colour index to {R,G,B}; index bit2/1/0 saturate R/G/B.
//   index  in  IDX_W   palette index
//   rgb    out 3*CH_W  channel-saturated colour
module lights_palette
   import lights_pkg::*;
#(
   parameter int CH_W = CH_W_DEF
) (
   input  logic [IDX_W-1:0]  index,
   output logic [3*CH_W-1:0] rgb
);
   assign rgb = {{CH_W{index[2]}}, {CH_W{index[1]}}, {CH_W{index[0]}}};
endmodule

// File: rtl/lights_sequencer.sv
// lights_sequencer: steps a colour index through the palette on button presses or at a dwell rate.
//   clk, rst_n  clock, async active-low reset
//   sel         force white output and freeze sequencing
//   button      advance request (pre-synchronised)
//   mode        0 = step per button rise, 1 = auto-step every DWELL cycles while held
//   dir         1 = forward, 0 = reverse
//   light       registered RGB output
//   colour      current index, always in 1..NUM_COLOURS
//   wrap        one-cycle pulse after a wrapping advance
module lights_sequencer
   import lights_pkg::*;
#(
   parameter int CH_W        = CH_W_DEF,
   parameter int NUM_COLOURS = 6,
   parameter int DWELL       = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sel,
   input  logic              button,
   input  logic              mode,
   input  logic              dir,
   output logic [3*CH_W-1:0] light,
   output logic [IDX_W-1:0]  colour,
   output logic              wrap
);
   localparam int   CNT_W = DWELL > 1 ? $clog2(DWELL) : 1;
   localparam idx_t LAST  = idx_t'(NUM_COLOURS);

   if (NUM_COLOURS < 2 || NUM_COLOURS > 6) begin : g_bad_colours
      $error("lights_sequencer: NUM_COLOURS must be 2..6");
   end
   if (DWELL < 1) begin : g_bad_dwell
      $error("lights_sequencer: DWELL must be >= 1");
   end

   logic             button_q;
   logic             mode_q;
   logic [CNT_W-1:0] dwell_cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             rise;
   logic             dwell_run;
   logic             dwell_fire;
   logic             adv;
   idx_t             colour_nxt;
   logic             wrap_nxt;
   idx_t             pal_idx;
   logic [3*CH_W-1:0] pal_rgb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         button_q  <= 1'b0;
         mode_q    <= 1'b0;
         dwell_cnt <= '0;
         colour    <= COL_BLUE;
         wrap      <= 1'b0;
         light     <= {{(2*CH_W){1'b0}}, {CH_W{1'b1}}};
      end else begin
         button_q  <= button;
         mode_q    <= mode;
         dwell_cnt <= cnt_nxt;
         colour    <= colour_nxt;
         wrap      <= wrap_nxt;
         light     <= pal_rgb;
      end
   end

   // a mode flip restarts the dwell so the first auto step is a full DWELL away
   always_comb begin
      rise       = button & ~button_q;
      dwell_run  = mode & button & ~sel & (mode == mode_q);
      dwell_fire = dwell_run & (dwell_cnt == CNT_W'(DWELL - 1));
      cnt_nxt    = (dwell_run & ~dwell_fire) ? dwell_cnt + 1'b1 : '0;
      adv        = mode ? dwell_fire : rise & ~sel;
      colour_nxt = !adv ? colour
                 : dir  ? (colour == LAST ? COL_BLUE : colour + 1'b1)
                 :        (colour == COL_BLUE ? LAST : colour - 1'b1);
      wrap_nxt   = adv & (dir ? colour == LAST : colour == COL_BLUE);
   end

   always_comb pal_idx = sel ? COL_WHITE : colour;

   lights_palette #(.CH_W(CH_W)) u_palette (
      .index (pal_idx),
      .rgb   (pal_rgb)
   );
endmodule

// File: tb/tb_lights_sequencer.sv
// tb_lights_sequencer: two configurations driven in lockstep against a cycle-level reference model.
module tb_lights_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        button = 1'b0;
   logic        mode = 1'b0;
   logic        dir = 1'b1;
   logic [23:0] light0;
   logic [11:0] light1;
   logic [2:0]  colour0, colour1;
   logic        wrap0, wrap1;

   int checks = 0;
   int errors = 0;
   int n[2] = '{6, 3};
   int d[2] = '{4, 1};
   int w[2] = '{8, 4};
   int m_col[2], m_run[2], m_lidx[2], wraps[2];
   bit m_wrap[2];
   bit p_btn, p_mode;
   logic [23:0] seq[6] = '{24'h00FF00, 24'h00FFFF, 24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'h0000FF};

   always #5 clk = ~clk;

   lights_sequencer dut0 (
      .clk(clk), .rst_n(rst_n), .sel(sel), .button(button), .mode(mode), .dir(dir),
      .light(light0), .colour(colour0), .wrap(wrap0)
   );

   lights_sequencer #(.CH_W(4), .NUM_COLOURS(3), .DWELL(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .sel(sel), .button(button), .mode(mode), .dir(dir),
      .light(light1), .colour(colour1), .wrap(wrap1)
   );

   function automatic logic [23:0] rgb(int idx, int cw);
      logic [23:0] ones = 24'((1 << cw) - 1);
      return (((idx / 4) % 2 == 1) ? ones << (2 * cw) : 24'h0)
           | (((idx / 2) % 2 == 1) ? ones << cw : 24'h0)
           | ((idx % 2 == 1) ? ones : 24'h0);
   endfunction

   task automatic check(string tag, logic [23:0] got, logic [23:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all(string tag);
      check({tag, ".colour0"}, 24'(colour0), 24'(m_col[0]));
      check({tag, ".light0"}, light0, rgb(m_lidx[0], w[0]));
      check({tag, ".wrap0"}, 24'(wrap0), 24'(m_wrap[0]));
      check({tag, ".colour1"}, 24'(colour1), 24'(m_col[1]));
      check({tag, ".light1"}, 24'(light1), rgb(m_lidx[1], w[1]));
      check({tag, ".wrap1"}, 24'(wrap1), 24'(m_wrap[1]));
   endtask

   task automatic mreset();
      for (int c = 0; c < 2; c++) begin
         m_col[c] = 1; m_run[c] = 0; m_lidx[c] = 1; m_wrap[c] = 0;
      end
      p_btn = 0; p_mode = 0;
   endtask

   task automatic tick(string tag);
      bit elig, adv;
      int nc;
      @(posedge clk);
      for (int c = 0; c < 2; c++) begin
         elig = mode && button && !sel && (mode == p_mode);
         m_run[c] = elig ? m_run[c] + 1 : 0;
         adv = !sel && (mode ? (elig && (m_run[c] % d[c] == 0)) : (button && !p_btn));
         m_lidx[c] = sel ? 7 : m_col[c];
         m_wrap[c] = 0;
         if (adv) begin
            nc = dir ? m_col[c] % n[c] + 1 : (m_col[c] == 1 ? n[c] : m_col[c] - 1);
            m_wrap[c] = dir ? (nc == 1) : (nc == n[c]);
            m_col[c] = nc;
         end
      end
      p_btn = button;
      p_mode = mode;
      #1;
      if (wrap0) wraps[0]++;
      if (wrap1) wraps[1]++;
      check_all(tag);
   endtask

   task automatic do_reset();
      rst_n = 0; sel = 0; button = 0; mode = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #($urandom_range(1, 4));
      rst_n = 1;
      mreset();
      check_all("reset");
      check("reset.light0_const", light0, 24'h0000FF);
      check("reset.light1_const", 24'(light1), 24'h00F);
   endtask

   initial begin
      mreset();
      dir = 1;
      do_reset();

      wraps = '{0, 0};
      for (int i = 0; i < 6; i++) begin
         button = 1; tick("m0_fwd_press");
         button = 0; tick("m0_fwd_gap");
         check("m0_fwd_seq", light0, seq[i]);
         tick("m0_fwd_gap2");
      end
      check("m0_fwd_wraps0", 24'(wraps[0]), 24'd1);
      check("m0_fwd_wraps1", 24'(wraps[1]), 24'd2);

      button = 1;
      repeat (10) tick("m0_hold");
      check("m0_hold_one_step", 24'(colour0), 24'd2);
      button = 0; tick("m0_release");

      mode = 1; tick("m1_enter");
      wraps = '{0, 0};
      button = 1;
      for (int i = 1; i <= 24; i++) begin
         tick("m1_auto");
         if (i == 3) check("m1_before_first", 24'(colour0), 24'd2);
         if (i == 4) check("m1_first_step", 24'(colour0), 24'd3);
      end
      check("m1_full_loop0", 24'(colour0), 24'd2);
      check("m1_full_loop1", 24'(colour1), 24'd2);
      check("m1_wraps0", 24'(wraps[0]), 24'd1);
      check("m1_wraps1", 24'(wraps[1]), 24'd8);
      button = 0;
      repeat (20) tick("m1_frozen");
      check("m1_frozen_colour", 24'(colour0), 24'd2);

      do_reset();
      dir = 0;
      button = 1; tick("rev_press");
      check("rev_colour0", 24'(colour0), 24'd6);
      check("rev_wrap0", 24'(wrap0), 24'd1);
      check("rev_colour1", 24'(colour1), 24'd3);
      button = 0; tick("rev_gap");
      check("rev_light0", light0, 24'hFFFF00);
      check("rev_light1", 24'(light1), 24'h0FF);
      check("rev_wrap_pulse", 24'(wrap0), 24'd0);
      button = 1; tick("rev_press2");
      button = 0; tick("rev_gap2");
      check("rev2_colour0", 24'(colour0), 24'd5);
      check("rev2_light0", light0, 24'hFF00FF);

      sel = 1; mode = 1;
      for (int i = 0; i < 10; i++) begin
         button = 1'($urandom_range(0, 1));
         tick("sel_freeze");
         check("sel_white", light0, 24'hFFFFFF);
         check("sel_colour", 24'(colour0), 24'd5);
      end
      mode = 0; button = 1; tick("sel_hold");
      sel = 0; tick("sel_release");
      check("sel_restore_light", light0, 24'hFF00FF);
      check("sel_restore_colour", 24'(colour0), 24'd5);
      tick("sel_no_step");
      check("sel_no_step_colour", 24'(colour0), 24'd5);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) button = ~button;
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         sel = ($urandom_range(0, 7) == 0);
         dir = 1'($urandom_range(0, 1));
         tick("random");
      end

      @(posedge clk);
      #3;
      rst_n = 0;
      #1;
      mreset();
      check_all("async_rst");
      check("async_rst.light0_const", light0, 24'h0000FF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
